// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from VGA sync strobes and checks the 800x525 raster timing.
// Define VGA_SYNC_DECODER_ERRCNT_EN to build the saturating err_count violation counter.
module vga_sync_decoder #(
    parameter logic [9:0] H_TOTAL = 10'd800,
    parameter logic [9:0] V_TOTAL = 10'd525,
    parameter logic [9:0] H_ON_LO = 10'd144,
    parameter logic [9:0] H_ON_HI = 10'd784,
    parameter logic [9:0] V_ON_LO = 10'd35,
    parameter logic [9:0] V_ON_HI = 10'd515
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hsync_n,
    input  logic       vsync_n,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       on_h,
    output logic       on_v,
    output logic       video_on,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t     state_q, state_d;
    logic       hs_q, vs_q;
    logic       pend_q, pend_d;
    logic       lbad_q, lbad_d;
    logic       err_q, err_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hfall, vfall, reload, line_bad, frame_good;

    assign hfall      = pix_en & hs_q & ~hsync_n;
    assign vfall      = pix_en & vs_q & ~vsync_n;
    // A vsync fall takes effect at the next hsync fall, or immediately if both fall together.
    assign reload     = hfall & (pend_q | vfall);
    assign line_bad   = hfall & (hcnt_q != H_TOTAL - 10'd1);
    assign frame_good = (vcnt_q == V_TOTAL - 10'd1) & ~lbad_q & ~line_bad;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        pend_d = pend_q;
        lbad_d = lbad_q;
        if (pix_en) begin
            if (hfall)
                hcnt_d = '0;
            else if (hcnt_q != 10'h3FF)
                hcnt_d = hcnt_q + 10'd1;
        end
        if (reload) begin
            vcnt_d = '0;
            pend_d = 1'b0;
            lbad_d = 1'b0;
        end else begin
            if (hfall && vcnt_q != 10'h3FF)
                vcnt_d = vcnt_q + 10'd1;
            if (vfall)
                pend_d = 1'b1;
            if (line_bad)
                lbad_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH: if (reload) state_d = VERIFY;
            VERIFY: if (reload && frame_good) state_d = LOCKED;
            LOCKED: begin
                if (line_bad || (reload && !frame_good)) begin
                    state_d = VERIFY;
                    err_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            pend_q  <= 1'b0;
            lbad_q  <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            if (pix_en) begin
                state_q <= state_d;
                hs_q    <= hsync_n;
                vs_q    <= vsync_n;
                pend_q  <= pend_d;
                lbad_q  <= lbad_d;
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
            end
        end
    end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    logic [7:0] ecnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            ecnt_q <= '0;
        else if (err_d && ecnt_q != 8'hFF)
            ecnt_q <= ecnt_q + 8'd1;
    end

    assign err_count = ecnt_q;
`else
    assign err_count = 8'd0;
`endif

    assign hCount   = hcnt_q;
    assign vCount   = vcnt_q;
    assign on_h     = (hcnt_q >= H_ON_LO) && (hcnt_q < H_ON_HI);
    assign on_v     = (vcnt_q >= V_ON_LO) && (vcnt_q < V_ON_HI);
    assign locked   = (state_q == LOCKED);
    assign video_on = locked & on_h & on_v;
    assign err      = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives sync waveforms on a scaled 10x6 raster into one decoder and checks it against a positional
// model every cycle; a second default-geometry instance pins the 640x480 active-window thresholds.
`timescale 1ns/1ps
module tb_vga_sync_decoder;
    localparam int HT = 10, VT = 6, HSW = 2;
    localparam int HLO = 3, HHI = 9, VLO = 1, VHI = 5;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    localparam bit ECNT = 1'b1;
`else
    localparam bit ECNT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, pix_en, hsync_n, vsync_n;
    logic [9:0] hCount, vCount;
    logic       on_h, on_v, video_on, locked, err;
    logic [7:0] err_count;

    logic       d_reset, d_pix, d_h, d_v;
    logic [9:0] d_hCount, d_vCount;
    logic       d_on_h, d_on_v, d_video_on, d_locked, d_err;
    logic [7:0] d_err_count;

    vga_sync_decoder #(
        .H_TOTAL(10'(HT)), .V_TOTAL(10'(VT)),
        .H_ON_LO(10'(HLO)), .H_ON_HI(10'(HHI)),
        .V_ON_LO(10'(VLO)), .V_ON_HI(10'(VHI))
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .hCount(hCount), .vCount(vCount), .on_h(on_h), .on_v(on_v), .video_on(video_on),
        .locked(locked), .err(err), .err_count(err_count)
    );

    vga_sync_decoder dflt (
        .clk(clk), .reset(d_reset), .pix_en(d_pix), .hsync_n(d_h), .vsync_n(d_v),
        .hCount(d_hCount), .vCount(d_vCount), .on_h(d_on_h), .on_v(d_on_v), .video_on(d_video_on),
        .locked(d_locked), .err(d_err), .err_count(d_err_count)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: positions are differences of running sample/line totals; lock is a 3-way mode.
    int nsamp = 0, hfall_at = 0, nlines = 0, reload_at = 0, mode = 0, m_ecnt = 0;
    int len, flines;
    bit ph, pv, pend, fbad, m_err, model_on = 1'b0;
    bit hf, vf, lbad, good;

    always @(posedge clk) begin
        if (reset) begin
            ph = 1'b1; pv = 1'b1; pend = 1'b0; fbad = 1'b0; mode = 0; m_err = 1'b0; m_ecnt = 0;
            hfall_at = nsamp; reload_at = nlines; model_on = 1'b1;
        end else begin
            m_err = 1'b0;
            if (pix_en) begin
                nsamp++;
                hf = ph && !hsync_n;
                vf = pv && !vsync_n;
                ph = hsync_n;
                pv = vsync_n;
                if (hf) begin
                    len = nsamp - hfall_at;
                    lbad = (len != HT);
                    nlines++;
                    hfall_at = nsamp;
                    if (pend || vf) begin
                        flines = nlines - reload_at;
                        good = (flines == VT) && !fbad && !lbad;
                        if (mode == 0) mode = 1;
                        else if (mode == 1) mode = good ? 2 : 1;
                        else if (!good) begin mode = 1; m_err = 1'b1; end
                        fbad = 1'b0; pend = 1'b0; reload_at = nlines;
                    end else begin
                        if (lbad) begin
                            fbad = 1'b1;
                            if (mode == 2) begin mode = 1; m_err = 1'b1; end
                        end
                        if (vf) pend = 1'b1;
                    end
                end else if (vf) pend = 1'b1;
                if (m_err && m_ecnt < 255) m_ecnt++;
            end
        end
    end

    int eh, ev;
    bit eoh, eov;
    always @(negedge clk) begin
        if (model_on) begin
            eh  = (nsamp - hfall_at > 1023) ? 1023 : nsamp - hfall_at;
            ev  = (nlines - reload_at > 1023) ? 1023 : nlines - reload_at;
            eoh = (eh >= HLO) && (eh < HHI);
            eov = (ev >= VLO) && (ev < VHI);
            chk("hCount", int'(hCount), eh);
            chk("vCount", int'(vCount), ev);
            chk("on_h", int'(on_h), int'(eoh));
            chk("on_v", int'(on_v), int'(eov));
            chk("locked", int'(locked), int'(mode == 2));
            chk("video_on", int'(video_on), int'((mode == 2) && eoh && eov));
            chk("err", int'(err), int'(m_err));
            chk("err_count", int'(err_count), ECNT ? m_ecnt : 0);
        end
    end

    bit cnt_en = 1'b0;
    int von = 0, nerr = 0;
    always @(negedge clk) begin
        if (cnt_en && video_on) von++;
        if (err) nerr++;
    end

    bit gappy = 1'b0;
    // One pixel sample; in gappy mode a pix_en=0 cycle with inverted syncs precedes it.
    task automatic pix(input logic h, input logic v);
        if (gappy) begin
            pix_en = 1'b0; hsync_n = ~h; vsync_n = ~v;
            @(negedge clk);
        end
        pix_en = 1'b1; hsync_n = h; vsync_n = v;
        @(negedge clk);
    endtask

    // Samples [k0,k1) of an ideal frame: line k/HT, pixel k%HT; vsync low for line 0.
    task automatic span(input int k0, input int k1);
        for (int k = k0; k < k1; k++)
            pix((k % HT) < HSW ? 1'b0 : 1'b1, (k / HT) == 0 ? 1'b0 : 1'b1);
    endtask

    // Ideal frame except line 2 is one pixel short.
    task automatic badframe();
        span(0, 2 * HT);
        for (int x = 0; x < HT - 1; x++) pix(x < HSW ? 1'b0 : 1'b1, 1'b1);
        span(3 * HT, HT * VT);
    endtask

    int n, e0;
    initial begin
        reset = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
        d_reset = 1'b1; d_pix = 1'b0; d_h = 1'b1; d_v = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0; d_reset = 1'b0;
        chk("rst_hCount", int'(hCount), 0);
        chk("rst_vCount", int'(vCount), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Default geometry: one hsync fall, then hCount sweeps to saturation.
        d_pix = 1'b1; d_h = 1'b0;
        @(negedge clk);
        d_h = 1'b1;
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (d_on_h) n++;
        end
        chk("dflt_on_h_width", n, 640);
        chk("dflt_hCount_sat", int'(d_hCount), 1023);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            d_h = 1'b0; @(negedge clk);
            d_h = 1'b1; @(negedge clk);
            if (d_on_v) n++;
        end
        chk("dflt_on_v_lines", n, 480);
        chk("dflt_vCount", int'(d_vCount), 601);
        chk("dflt_locked", int'(d_locked), 0);
        d_pix = 1'b0;

        // Three ideal frames; the second has pix_en gaps with misleading sync values.
        span(0, HT * VT);
        chk("locked_after_f1", int'(locked), 0);
        gappy = 1'b1;
        span(0, HT * VT);
        gappy = 1'b0;
        chk("locked_after_f2", int'(locked), 1);
        von = 0; cnt_en = 1'b1;
        span(0, HT * VT);
        cnt_en = 1'b0;
        chk("video_on_f3", von, (HHI - HLO) * (VHI - VLO));

        // Short line while locked.
        e0 = nerr;
        badframe();
        chk("err_pulses_badline", nerr - e0, 1);
        chk("locked_after_badline", int'(locked), 0);
        span(0, HT * VT);
        chk("locked_before_eval", int'(locked), 0);
        span(0, HT * VT);
        chk("relocked_after_badline", int'(locked), 1);

        // Short frame while locked: caught at the following vCount reload.
        e0 = nerr;
        span(0, HT * (VT - 1));
        chk("locked_short_pre", int'(locked), 1);
        span(0, 1);
        chk("short_frame_err", int'(err), 1);
        chk("short_frame_locked", int'(locked), 0);
        span(1, HT * VT);
        span(0, HT * VT);
        chk("err_pulses_short", nerr - e0, 1);
        chk("relocked_after_short", int'(locked), 1);

        // Simultaneous hsync/vsync fall from the last pixel of a frame.
        chk("pre_simul_h", int'(hCount), HT - 1);
        chk("pre_simul_v", int'(vCount), VT - 1);
        span(0, 1);
        chk("simul_h", int'(hCount), 0);
        chk("simul_v", int'(vCount), 0);

        // Reset mid-frame.
        span(1, 3 * HT + 6);
        chk("mid_h", int'(hCount), 5);
        chk("mid_v", int'(vCount), 3);
        reset = 1'b1; pix_en = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_hCount", int'(hCount), 0);
        chk("midrst_vCount", int'(vCount), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_video_on", int'(video_on), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_err_count", int'(err_count), 0);
        span(3 * HT + 7, HT * VT);
        span(0, HT * VT);
        chk("midrst_locked_f1", int'(locked), 0);
        span(0, HT * VT);
        chk("midrst_locked_f2", int'(locked), 1);

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        for (int i = 0; i < 3; i++) begin
            badframe();
            span(0, HT * VT);
            span(0, HT * VT);
        end
        chk("ecnt_3", int'(err_count), 3);
        for (int i = 0; i < 297; i++) begin
            span(0, HT * (VT - 1));
            span(0, HT * VT);
        end
        span(0, HT * VT);
        chk("ecnt_sat", int'(err_count), 255);
        chk("ecnt_relocked", int'(locked), 1);
`else
        badframe();
        span(0, HT * VT);
        chk("ecnt_tied", int'(err_count), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
